// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one fixed-latency divider among REQ_NUM requesters.
// Response DIV_LAT+2 cycles after acceptance (1 cycle on overflow/div-by-zero); holds until rsp_ready.
module div_scheduler #(
  parameter int WIDTH   = 4,
  parameter int REQ_NUM = 4,
  parameter int DIV_LAT = WIDTH + 1,
  localparam int IDW    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  localparam int CW     = $clog2(DIV_LAT + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REQ_NUM-1:0]         req_valid,
  output logic [REQ_NUM-1:0]         req_ready,
  input  logic [REQ_NUM*2*WIDTH-1:0] req_dividend,
  input  logic [REQ_NUM*WIDTH-1:0]   req_divisor,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic [WIDTH-1:0]           rsp_remainder,
  output logic                       rsp_err,
  output logic                       div_din_valid,
  output logic [2*WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic [WIDTH-1:0]           div_dout,
  input  logic [WIDTH-1:0]           div_remainder,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [IDW:0] RN_W = (IDW+1)'(REQ_NUM);

  state_t             state, state_nxt;
  logic [IDW-1:0]     rr_ptr;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] cap_dvd;
  logic [WIDTH-1:0]   cap_dvs;

  logic               found;
  logic [IDW-1:0]     gnt_idx;
  logic [IDW:0]       scan;
  logic [2*WIDTH-1:0] sel_dvd;
  logic [WIDTH-1:0]   sel_dvs;
  logic               sel_err;
  logic               accept;

  // First requesting index at or above rr_ptr, wrapping modulo REQ_NUM.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      scan = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan >= RN_W) scan = scan - RN_W;
      if (!found && req_valid[scan[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan[IDW-1:0];
      end
    end
  end

  assign sel_dvd = req_dividend[gnt_idx*(2*WIDTH) +: 2*WIDTH];
  assign sel_dvs = req_divisor[gnt_idx*WIDTH +: WIDTH];
  // Upper half >= divisor means the quotient cannot fit; also catches divisor 0.
  assign sel_err = (sel_dvd[2*WIDTH-1:WIDTH] >= sel_dvs);
  assign accept  = (state == IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (state == IDLE && rst_n && found) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = sel_err ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == CW'(1)) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      cap_dvd       <= '0;
      cap_dvs       <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_dvd <= sel_dvd;
            cap_dvs <= sel_dvs;
            rsp_id  <= gnt_idx;
            rr_ptr  <= (gnt_idx == IDW'(REQ_NUM-1)) ? '0 : gnt_idx + 1'b1;
            rsp_err <= sel_err;
            if (sel_err) begin
              rsp_quotient  <= '1;
              rsp_remainder <= '0;
            end
          end
        end
        ISSUE: cnt <= CW'(DIV_LAT);
        WAIT: begin
          if (cnt == CW'(1)) begin
            cnt           <= '0;
            rsp_quotient  <= div_dout;
            rsp_remainder <= div_remainder;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign rsp_valid     = (state == RESP);
  assign div_din_valid = (state == ISSUE);
  assign div_dividend  = (state == ISSUE || state == WAIT) ? cap_dvd : '0;
  assign div_divisor   = (state == ISSUE || state == WAIT) ? cap_dvs : '0;

endmodule

// File: tb/tb_div_scheduler.sv
// Self-checking bench for div_scheduler with a behavioural fixed-latency divider.
module tb_div_scheduler;
  localparam int WIDTH = 4, REQ_NUM = 4, DIV_LAT = 5;

  logic                       clk = 0;
  logic                       rst_n = 0;
  logic [REQ_NUM-1:0]         req_valid = '0;
  logic [REQ_NUM-1:0]         req_ready;
  logic [REQ_NUM*2*WIDTH-1:0] req_dividend = '0;
  logic [REQ_NUM*WIDTH-1:0]   req_divisor = '0;
  logic                       rsp_valid;
  logic                       rsp_ready = 0;
  logic [1:0]                 rsp_id;
  logic [WIDTH-1:0]           rsp_quotient, rsp_remainder;
  logic                       rsp_err;
  logic                       div_din_valid;
  logic [2*WIDTH-1:0]         div_dividend;
  logic [WIDTH-1:0]           div_divisor;
  logic [WIDTH-1:0]           div_dout = '0, div_remainder = '0;
  logic                       busy;

  div_scheduler #(.WIDTH(WIDTH), .REQ_NUM(REQ_NUM), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_err(rsp_err), .div_din_valid(div_din_valid),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_dout(div_dout),
    .div_remainder(div_remainder), .busy(busy));

  always #5 clk = ~clk;

  // Divider model: outputs are wrong until DIV_LAT cycles after the start pulse.
  int         m_cnt = 0;
  logic [3:0] m_q, m_r;
  always @(posedge clk) begin
    if (div_din_valid) begin
      m_cnt         <= DIV_LAT - 1;
      m_q           <= (div_divisor == 0) ? 4'hF : 4'((div_dividend / div_divisor));
      m_r           <= (div_divisor == 0) ? 4'h0 : 4'((div_dividend % div_divisor));
      div_dout      <= ~div_dout;
      div_remainder <= ~div_remainder;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        div_dout      <= m_q;
        div_remainder <= m_r;
      end
    end
  end

  int checks = 0, failures = 0;
  int rr = 0;
  int dvd_a [4];
  int dvs_a [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input int dvd, input int dvs, output int e, output int q, output int r);
    e = ((dvd / 16) >= dvs) ? 1 : 0;
    q = e ? 15 : dvd / dvs;
    r = e ? 0 : dvd % dvs;
  endfunction

  function automatic int ref_grant(input int mask, input int ptr);
    for (int k = 0; k < REQ_NUM; k++)
      if (mask[(ptr + k) % REQ_NUM]) return (ptr + k) % REQ_NUM;
    return -1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_din_valid"}, div_din_valid, 0);
    chk({tag, "_div_ops"}, {div_dividend, div_divisor}, 0);
    chk({tag, "_rsp_fields"}, {rsp_id, rsp_quotient, rsp_remainder, rsp_err}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req_valid = '1; rsp_ready = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk_reset_outputs("reset");
    rst_n = 1; req_valid = '0;
    rr = 0;
  endtask

  task automatic load_ops();
    for (int i = 0; i < REQ_NUM; i++) begin
      req_dividend[i*8 +: 8] = 8'(dvd_a[i]);
      req_divisor[i*4 +: 4]  = 4'(dvs_a[i]);
    end
  endtask

  // One transaction: grant check, latency, divider pulse, result, hold stability, release.
  task automatic run_op(input int mask, input int g, input int e_err, input int e_q, input int e_r, input int hold);
    int k, rsp_k, din_cnt, din_k, got;
    logic [10:0] snap;
    @(negedge clk);
    load_ops();
    req_valid = 4'(mask);
    #1;
    chk("grant", req_ready, 32'(1) << g);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rr = (g + 1) % REQ_NUM;
    k = 1; got = 0; din_cnt = 0; din_k = -1; rsp_k = -1;
    while (k <= 40 && !got) begin
      if (k > 1) @(negedge clk);
      if (div_din_valid) begin din_cnt++; din_k = k; end
      if (rsp_valid) begin got = 1; rsp_k = k; end
      else if (busy && div_dividend !== 8'(dvd_a[g])) chk("div_operand_hold", div_dividend, 8'(dvd_a[g]));
      k++;
    end
    chk("rsp_timeout", got, 1);
    chk("rsp_latency", rsp_k, e_err ? 1 : DIV_LAT + 2);
    chk("din_count", din_cnt, e_err ? 0 : 1);
    if (!e_err) chk("din_cycle", din_k, 1);
    chk("rsp_id", rsp_id, g);
    chk("rsp_err", rsp_err, e_err);
    chk("rsp_result", {rsp_quotient, rsp_remainder}, {4'(e_q), 4'(e_r)});
    snap = {rsp_id, rsp_quotient, rsp_remainder, rsp_err};
    if (got) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_stable", {rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err}, {1'b1, snap});
        chk("hold_busy_noready", {busy, req_ready}, {1'b1, 4'b0});
      end
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("release_idle", {rsp_valid, busy}, 0);
  endtask

  typedef struct {
    int mask; int g; int dvd; int dvs; int e_err; int e_q; int e_r; int hold;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int e, q, r, g, mask;
    tbl[0] = '{4'b0100, 2, 45,    7,  0, 6,  3,  0};
    tbl[1] = '{4'b0010, 1, 8'h23, 0,  1, 15, 0,  0};
    tbl[2] = '{4'b0001, 0, 8'h50, 3,  1, 15, 0,  0};
    tbl[3] = '{4'b0001, 0, 8'h2F, 3,  0, 15, 2,  6};
    tbl[4] = '{4'b1000, 3, 8'h0F, 1,  0, 15, 0,  0};
    tbl[5] = '{4'b0010, 1, 8'h30, 3,  1, 15, 0,  1};
    tbl[6] = '{4'b0100, 2, 8'hEF, 15, 0, 15, 14, 0};
    tbl[7] = '{4'b1000, 3, 8'h00, 5,  0, 0,  0,  2};
    tbl[8] = '{4'b0001, 0, 8'hFF, 15, 1, 15, 0,  0};

    do_reset();

    foreach (tbl[i]) begin
      for (int j = 0; j < REQ_NUM; j++) begin dvd_a[j] = tbl[i].dvd; dvs_a[j] = tbl[i].dvs; end
      run_op(tbl[i].mask, tbl[i].g, tbl[i].e_err, tbl[i].e_q, tbl[i].e_r, tbl[i].hold);
    end

    // Round-robin order with every requester asking after reset.
    do_reset();
    for (int j = 0; j < REQ_NUM; j++) begin dvd_a[j] = 8'h1C + j; dvs_a[j] = 5; end
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      foreach (order[i]) begin
        ref_div(dvd_a[order[i]], dvs_a[order[i]], e, q, r);
        run_op(4'hF, order[i], e, q, r, 0);
      end
    end

    // Reset while the divider is in flight discards the operation.
    dvd_a[1] = 8'h2B; dvs_a[1] = 4;
    @(negedge clk);
    load_ops();
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("midop_busy", {busy, rsp_valid}, 2'b10);
    rst_n = 0; req_valid = '1;
    @(negedge clk);
    chk("midreset_req_ready", req_ready, 0);
    chk_reset_outputs("midreset");
    rst_n = 1; req_valid = '0; rr = 0;
    begin
      int seen = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (rsp_valid || busy) seen++;
      end
      chk("no_stale_rsp", seen, 0);
    end
    for (int j = 0; j < REQ_NUM; j++) begin dvd_a[j] = 8'h3A + j; dvs_a[j] = 7; end
    ref_div(dvd_a[0], dvs_a[0], e, q, r);
    run_op(4'hF, 0, e, q, r, 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      mask = $urandom_range(1, 15);
      for (int j = 0; j < REQ_NUM; j++) begin
        dvd_a[j] = $urandom_range(0, 255);
        dvs_a[j] = $urandom_range(0, 15);
      end
      g = ref_grant(mask, rr);
      ref_div(dvd_a[g], dvs_a[g], e, q, r);
      run_op(mask, g, e, q, r, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 4, quotient/divisor/remainder width; dividend width is 2*WIDTH.
REQ-002 SHALL have parameter REQ_NUM, default 4, number of requesters sharing one divider; IDW = max(1, clog2(REQ_NUM)).
REQ-003 SHALL have parameter DIV_LAT, default WIDTH+1, cycles from divider din_valid until its dout/remainder are final.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  REQ_NUM  per-requester request.
REQ-007 req_ready  output  REQ_NUM  per-requester accept, at most one bit high.
REQ-008 req_dividend  input  REQ_NUM*2*WIDTH  packed dividends, requester i at slice i.
REQ-009 req_divisor  input  REQ_NUM*WIDTH  packed divisors, requester i at slice i.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed.
REQ-012 rsp_id  output  IDW  index of requester owning the response.
REQ-013 rsp_quotient  output  WIDTH  quotient.
REQ-014 rsp_remainder  output  WIDTH  remainder.
REQ-015 rsp_err  output  1  overflow or divide-by-zero; operation not issued.
REQ-016 div_din_valid  output  1  start pulse to shared divider.
REQ-017 div_dividend  output  2*WIDTH  operand to divider.
REQ-018 div_divisor  output  WIDTH  operand to divider.
REQ-019 div_dout  input  WIDTH  divider quotient.
REQ-020 div_remainder  input  WIDTH  divider remainder.
REQ-021 busy  output  1  high in any state except IDLE.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-023 In IDLE, req_ready[g] SHALL be high combinationally for g = first i with req_valid[i]=1 searching from rr_ptr upward modulo REQ_NUM; all other bits low; all bits low outside IDLE.
REQ-024 On acceptance (req_valid[g] & req_ready[g], edge T): capture dividend, divisor, g; rr_ptr <= (g+1) mod REQ_NUM.
REQ-025 Error check on captured operands: dividend[2W-1:W] >= divisor (covers divisor=0) SHALL go to RESP with rsp_err=1, rsp_quotient=all ones, rsp_remainder=0; divider not started; rsp_valid high from cycle T+1.
REQ-026 Otherwise go to ISSUE: div_din_valid high for exactly one cycle (cycle T+1); load counter with DIV_LAT.
REQ-027 div_dividend/div_divisor SHALL equal captured operands from ISSUE through end of WAIT, and be 0 in IDLE.
REQ-028 WAIT SHALL last DIV_LAT cycles; on its final edge capture div_dout/div_remainder into rsp_quotient/rsp_remainder, go to RESP.
REQ-029 Non-error latency: rsp_valid SHALL rise at cycle T+2+DIV_LAT.
REQ-030 RESP: rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err SHALL hold stable until rsp_valid & rsp_ready; then IDLE next cycle, rsp_valid low.
REQ-031 No new request SHALL be accepted while busy=1; one operation in flight maximum.
REQ-032 req_valid deassertion after acceptance SHALL NOT affect the in-flight operation.
REQ-033 DIV_LAT counter SHALL use clog2(DIV_LAT+1) bits, no wrap.

Reset
REQ-034 With rst_n=0 at an edge: state IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_err=0, div_din_valid=0, div_dividend=0, div_divisor=0, busy=0, counter 0.
REQ-035 Reset during ISSUE/WAIT/RESP SHALL discard the operation; no response for it ever produced; req_ready low while rst_n=0.

Verification
REQ-036 Bench drives a behavioral divider model returning results DIV_LAT cycles after div_din_valid; WIDTH=4, REQ_NUM=4, DIV_LAT=5.
REQ-037 Req 2 only, dividend 45, divisor 7, accepted at T -> one div_din_valid at T+1; rsp_valid at T+7, rsp_id=2, quotient 6, remainder 3, rsp_err 0.
REQ-038 All four req_valid held high after reset, rsp_ready=1 -> grant order 0,1,2,3,0; each req_ready one cycle; responses carry matching rsp_id.
REQ-039 Req 1 dividend 8'h23, divisor 0 -> rsp_valid at T+1, rsp_err=1, quotient 4'hF, remainder 0; div_din_valid never high.
REQ-040 Req 0 dividend 8'h50, divisor 3 -> rsp_err=1, no divider start; then dividend 8'h2F, divisor 3 -> quotient 15, remainder 2, rsp_err 0.
REQ-041 rsp_ready low 6 cycles in RESP -> all rsp_* stable, req_ready all low, busy=1; rsp_ready high -> IDLE next cycle.
REQ-042 rst_n low for one edge during WAIT -> all outputs at reset values next cycle, no response; new request afterwards served normally with rr_ptr=0.
